// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched: four-lane round-robin scheduler for the phy_tx output stage.
// Optional macro LANE_SCHED_TDM_EN selects strict time-division slots.
module phy_tx_lane_sched #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  IDLE_SYM   = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] data_in_3,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  input  logic       valid_in_2,
  input  logic       valid_in_3,
  output logic [3:0] grant,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic [1:0] state_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic [1:0] state;
  logic [1:0] rr_ptr;
  logic [3:0] sync_cnt;
  logic [3:0] valid_vec;
  logic [7:0] lane_data [4];
  logic       run;
  logic       pick_hit;
  logic [1:0] pick_idx;

  assign valid_vec = {valid_in_3, valid_in_2,
                      valid_in_1, valid_in_0};
  assign lane_data[0] = data_in_0;
  assign lane_data[1] = data_in_1;
  assign lane_data[2] = data_in_2;
  assign lane_data[3] = data_in_3;

  // Arbitration only runs in ACTIVE with enable high and no reset.
  assign run = (state == ST_ACTIVE) && enable && !reset;
  assign state_out = state;

`ifdef LANE_SCHED_TDM_EN
  // Only the slot owner may transmit in its slot.
  always_comb begin
    pick_idx = rr_ptr;
    pick_hit = valid_vec[rr_ptr];
  end
`else
  // First valid lane at or after the pointer wins.
  always_comb begin
    logic [1:0] cand;
    pick_hit = 1'b0;
    pick_idx = rr_ptr;
    cand     = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!pick_hit && valid_vec[cand]) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end
  end
`endif

  // One-hot grant, suppressed outside a running ACTIVE cycle.
  always_comb begin
    grant = 4'b0000;
    if (run && pick_hit)
      grant = 4'b0001 << pick_idx;
  end

  // State machine, pointer and registered output word.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 2'd0;
      sync_cnt  <= 4'd0;
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      lane_out  <= 2'd0;
    end else if (!enable) begin
      state     <= ST_IDLE;
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
    end else begin
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          state    <= ST_SYNC;
          sync_cnt <= 4'd0;
        end
        (state == ST_SYNC): begin
          sync_cnt <= sync_cnt + 4'd1;
          if (sync_cnt == SYNC_LAST)
            state <= ST_ACTIVE;
        end
        (state == ST_ACTIVE): begin
`ifdef LANE_SCHED_TDM_EN
          rr_ptr   <= rr_ptr + 2'd1;
          lane_out <= rr_ptr;
          if (pick_hit) begin
            data_out  <= lane_data[pick_idx];
            valid_out <= 1'b1;
          end
`else
          if (pick_hit) begin
            data_out  <= lane_data[pick_idx];
            valid_out <= 1'b1;
            lane_out  <= pick_idx;
            rr_ptr    <= pick_idx + 2'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// tb_phy_tx_lane_sched: directed vector table plus randomized model check.
// Honours LANE_SCHED_TDM_EN to select the expected arbitration mode.
module tb_phy_tx_lane_sched;

  localparam int SYNC_N = 4;
  localparam logic [7:0] BC = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic [3:0] grant;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [1:0] state_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_4f = ~clk_4f;

  phy_tx_lane_sched #(
    .SYNC_COUNT(SYNC_N),
    .IDLE_SYM(BC)
  ) dut (
    .clk_4f(clk_4f),
    .reset(reset),
    .enable(enable),
    .data_in_0(din[0]),
    .data_in_1(din[1]),
    .data_in_2(din[2]),
    .data_in_3(din[3]),
    .valid_in_0(vin[0]),
    .valid_in_1(vin[1]),
    .valid_in_2(vin[2]),
    .valid_in_3(vin[3]),
    .grant(grant),
    .data_out(data_out),
    .valid_out(valid_out),
    .lane_out(lane_out),
    .state_out(state_out)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  g;
    logic [1:0]  st;
    logic        vo;
    logic [7:0]  dout;
    logic [1:0]  lo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] v,
                              logic [31:0] d, logic [3:0] g,
                              logic [1:0] st, logic vo,
                              logic [7:0] dout, logic [1:0] lo);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v; r.d = d; r.g = g;
    r.st = st; r.vo = vo; r.dout = dout; r.lo = lo;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en,
                       input logic [3:0] v, input logic [31:0] d);
    reset  = rst;
    enable = en;
    vin    = v;
    for (int i = 0; i < 4; i++) din[i] = d[8*i +: 8];
  endtask

  // Reference model state (spec-level).
  int         m_st;
  int         m_ptr;
  int         m_sync;
  logic [7:0] m_do;
  logic       m_vo;
  int         m_lo;

  function automatic int m_pick();
    if (reset || !enable || m_st != 2) return -1;
`ifdef LANE_SCHED_TDM_EN
    return vin[m_ptr] ? m_ptr : -1;
`else
    for (int k = 0; k < 4; k++)
      if (vin[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
`endif
  endfunction

  task automatic m_step();
    int p;
    p = m_pick();
    if (reset) begin
      m_st = 0; m_ptr = 0; m_sync = 0;
      m_do = BC; m_vo = 0; m_lo = 0;
    end else if (!enable) begin
      m_st = 0; m_do = BC; m_vo = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_sync = 0; m_do = BC; m_vo = 0;
    end else if (m_st == 1) begin
      m_sync++;
      if (m_sync == SYNC_N) m_st = 2;
      m_do = BC; m_vo = 0;
    end else begin
`ifdef LANE_SCHED_TDM_EN
      m_lo  = m_ptr;
      m_ptr = (m_ptr + 1) % 4;
`endif
      if (p >= 0) begin
        m_do = din[p];
        m_vo = 1;
`ifndef LANE_SCHED_TDM_EN
        m_lo  = p;
        m_ptr = (p + 1) % 4;
`endif
      end else begin
        m_do = BC;
        m_vo = 0;
      end
    end
  endtask

  initial begin
    logic [31:0] F, S;
    logic [3:0]  eg;
    int          p;
    F = 32'h43322110;
    S = 32'hA355A155;

    tbl.push_back(mk(1, 0, 4'h0, F, 4'h0, 0, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'h0, F, 4'h0, 0, 0, BC, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 4'h0, F, 4'h0, 1, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h1, 2, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h2, 2, 1, 8'h10, 0));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h4, 2, 1, 8'h21, 1));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h8, 2, 1, 8'h32, 2));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h1, 2, 1, 8'h43, 3));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h2, 2, 1, 8'h10, 0));
    tbl.push_back(mk(0, 0, 4'hF, F, 4'h0, 2, 1, 8'h21, 1));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h0, 0, 0, BC, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 4'hF, F, 4'h0, 1, 0, BC, 1));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h4, 2, 0, BC, 1));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h8, 2, 1, 8'h32, 2));
`ifdef LANE_SCHED_TDM_EN
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h0, 2, 1, 8'h43, 3));
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h2, 2, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h0, 2, 1, 8'hA1, 1));
    tbl.push_back(mk(0, 1, 4'h0, S, 4'h0, 2, 0, BC, 2));
    tbl.push_back(mk(0, 1, 4'h0, S, 4'h0, 2, 0, BC, 3));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h2, 2, 0, BC, 0));
    tbl.push_back(mk(1, 1, 4'hF, F, 4'h0, 2, 1, 8'h21, 1));
`else
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h2, 2, 1, 8'h43, 3));
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h8, 2, 1, 8'hA1, 1));
    tbl.push_back(mk(0, 1, 4'hA, S, 4'h2, 2, 1, 8'hA3, 3));
    tbl.push_back(mk(0, 1, 4'h0, S, 4'h0, 2, 1, 8'hA1, 1));
    tbl.push_back(mk(0, 1, 4'h0, S, 4'h0, 2, 0, BC, 1));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h4, 2, 0, BC, 1));
    tbl.push_back(mk(1, 1, 4'hF, F, 4'h0, 2, 1, 8'h32, 2));
`endif
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h0, 0, 0, BC, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 4'hF, F, 4'h0, 1, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h1, 2, 0, BC, 0));
    tbl.push_back(mk(0, 1, 4'hF, F, 4'h2, 2, 1, 8'h10, 0));

    drive(1, 0, 4'h0, 32'h0);
    repeat (2) @(posedge clk_4f);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].d);
      #4;
      nvec++;
      chk("grant", i, {4'h0, grant}, {4'h0, tbl[i].g});
      chk("state", i, {6'h0, state_out}, {6'h0, tbl[i].st});
      chk("valid_out", i, {7'h0, valid_out}, {7'h0, tbl[i].vo});
      chk("data_out", i, data_out, tbl[i].dout);
      chk("lane_out", i, {6'h0, lane_out}, {6'h0, tbl[i].lo});
      @(posedge clk_4f);
      #1;
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      drive((c == 0) || ($urandom_range(0, 59) == 0),
            $urandom_range(0, 24) != 0,
            4'($urandom_range(0, 15)),
            $urandom);
      #4;
      if (c > 0) begin
        p  = m_pick();
        eg = (p >= 0) ? (4'b0001 << p) : 4'b0000;
        nvec++;
        chk("rnd_grant", c, {4'h0, grant}, {4'h0, eg});
        chk("rnd_state", c, {6'h0, state_out}, 8'(m_st));
        chk("rnd_valid", c, {7'h0, valid_out}, {7'h0, m_vo});
        chk("rnd_data", c, data_out, m_do);
        chk("rnd_lane", c, {6'h0, lane_out}, 8'(m_lo));
      end
      @(posedge clk_4f);
      m_step();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/phy_tx_lane_sched.md
Name: phy_tx_lane_sched

Overview:
- Round-robin scheduler that shares the single 8-bit transmit output stage of phy_tx among four lane sources.
- Sits between the four per-lane buffers and the serializer, all in the clk_4f domain.
- Issues a one-hot grant to exactly one lane per cycle. Emits an alignment preamble after enable, and the idle symbol whenever no lane is granted.

Parameters:
- SYNC_COUNT, 4, number of clk_4f cycles of idle symbol sent in SYNC before data is allowed (range 1..15).
- IDLE_SYM, 8'hBC, symbol driven on data_out whenever valid_out is 0.

Ports:
- clk_4f  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scheduler enable; low forces IDLE.
- data_in_0 .. data_in_3  input  8 each  lane data.
- valid_in_0 .. valid_in_3  input  1 each  lane has a word available.
- grant  output  4  one-hot, combinational; grant[i]=1 means lane i's word is consumed at this edge.
- data_out  output  8  registered scheduled word.
- valid_out  output  1  registered; 1 when data_out carries lane data.
- lane_out  output  2  registered index of the lane that produced data_out.
- state_out  output  2  current state encoding: IDLE=0, SYNC=1, ACTIVE=2.

Behaviour:
- Interface decision: one clock (clk_4f); reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr pointer=0, sync counter=0.
  - data_out=IDLE_SYM, valid_out=0, lane_out=0, grant=0.
- States:
  - IDLE: no grants; data_out=IDLE_SYM, valid_out=0. enable=1 -> SYNC next cycle, with the sync counter cleared.
  - SYNC: no grants; data_out=IDLE_SYM, valid_out=0. Counter increments each cycle. After SYNC_COUNT cycles in SYNC -> ACTIVE.
  - ACTIVE: arbitration runs every cycle.
  - enable=0 in any state -> IDLE next cycle. grant is forced to 0 combinationally in the same cycle enable is low.
- Arbitration (default, work-conserving):
  - Search lanes starting at the rr pointer: ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The first lane with valid_in=1 is granted.
- On the edge with grant[i]=1:
  - data_out <= data_in_i, valid_out <= 1, lane_out <= i.
  - rr pointer <= (i+1) mod 4, wrapping 3 -> 0.
- On an ACTIVE edge with no valid lane:
  - data_out <= IDLE_SYM, valid_out <= 0.
  - lane_out and rr pointer hold.
- Latency: a word on data_in_i with grant[i]=1 appears on data_out one clk_4f edge later.
- At most one grant bit is set per cycle; throughput is one word per cycle.
- A lane whose valid stays high is served at least once every 4 cycles (no starvation).
- valid_in changes take effect in the same cycle (grant is combinational); lanes must not make valid depend on grant.
- reset mid-operation:
  - Takes priority over enable.
  - Returns all outputs to reset values at the next edge.
  - The word that would have been granted is not consumed (grant=0 while reset=1).
- Leaving ACTIVE: the word presented on the cycle enable drops is not granted. Re-entering always passes through SYNC again.

Optional Feature:
- Macro LANE_SCHED_TDM_EN.
- When defined: strict time-division mode.
  - In ACTIVE the rr pointer advances by 1 every cycle regardless of traffic.
  - Only the pointer lane may be granted, and only if its valid_in=1.
  - Otherwise that slot emits IDLE_SYM with valid_out=0.
  - lane_out equals the slot index even for idle slots.
- When undefined: work-conserving round-robin as above.
- Ports are identical in both builds.

Test Plan:
- Reset/SYNC: reset=1 for 2 cycles, then enable=1 with all valids low -> state_out 0 -> 1 for 4 cycles -> 2. data_out=8'hBC and valid_out=0 throughout; grant=0 until ACTIVE.
- Full load: all valid=1 with data 8'h10/8'h21/8'h32/8'h43 -> grant sequence 0001, 0010, 0100, 1000, repeating. data_out 10, 21, 32, 43 one cycle later, lane_out 0, 1, 2, 3.
- Sparse (default build): only lanes 1 and 3 valid (8'hA1, 8'hA3) -> grants alternate 0010/1000 with no idle gaps. Then all valid low -> data_out=8'hBC, valid_out=0, lane_out held.
- Sparse (TDM build): same stimulus -> data_out BC, A1, BC, A3 repeating; valid_out 0, 1, 0, 1.
- Mid-operation disable: drop enable while lane 2 is next -> grant=0 in the same cycle, state IDLE next cycle. Re-enable -> 4 SYNC cycles, then lane 2 is granted first (pointer retained).
- Reset mid-traffic: assert reset during full load -> next edge gives data_out=8'hBC, valid_out=0, lane_out=0, state IDLE. After reset, lane 0 is the first granted.
